// File: rtl/fetch_unit_pkg.sv
// Shared constants and helpers for the copperv instruction-fetch front end.
package fetch_unit_pkg;

  localparam int unsigned PC_WIDTH_DEF   = 32;
  localparam int unsigned INST_WIDTH_DEF = 32;
  localparam int unsigned FETCH_PC_INCR  = 4;

  // Width of a counter that must hold values 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-bus read channel between the fetch unit (master) and memory (slave).
interface fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int unsigned PC_WIDTH   = PC_WIDTH_DEF,
  parameter int unsigned INST_WIDTH = INST_WIDTH_DEF
);

  logic                  i_raddr_valid;
  logic                  i_raddr_ready;
  logic [PC_WIDTH-1:0]   i_raddr;
  logic                  i_rdata_valid;
  logic                  i_rdata_ready;
  logic [INST_WIDTH-1:0] i_rdata;

  modport master (
    output i_raddr_valid, i_raddr, i_rdata_ready,
    input  i_raddr_ready, i_rdata_valid, i_rdata
  );

  modport slave (
    input  i_raddr_valid, i_raddr, i_rdata_ready,
    output i_raddr_ready, i_rdata_valid, i_rdata
  );

endinterface

// File: rtl/fetch_unit_queue.sv
// In-order fetch queue: entries are allocated at issue, filled on response, and
// read at the head. Flush drops every entry and rewinds all pointers.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int unsigned PC_WIDTH   = PC_WIDTH_DEF,
  parameter int unsigned INST_WIDTH = INST_WIDTH_DEF,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           alloc_en,
  input  logic [PC_WIDTH-1:0]            alloc_pc,
  input  logic                           fill_en,
  input  logic [INST_WIDTH-1:0]          fill_data,
  input  logic                           read_en,
  output logic                           head_valid,
  output logic [INST_WIDTH-1:0]          head_inst,
  output logic [PC_WIDTH-1:0]            head_pc,
  output logic [cnt_width(DEPTH)-1:0]    alloc_cnt,
  output logic [cnt_width(DEPTH)-1:0]    pend_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);

  logic [PC_WIDTH-1:0]   pc_mem   [DEPTH];
  logic [INST_WIDTH-1:0] inst_mem [DEPTH];
  logic [DEPTH-1:0]      filled;
  logic [PW-1:0]         alloc_ptr;
  logic [PW-1:0]         fill_ptr;
  logic [PW-1:0]         read_ptr;

  assign head_valid = filled[read_ptr];
  assign head_inst  = inst_mem[read_ptr];
  assign head_pc    = pc_mem[read_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      read_ptr  <= '0;
      alloc_cnt <= '0;
      pend_cnt  <= '0;
      filled    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
    end else if (flush) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      read_ptr  <= '0;
      alloc_cnt <= '0;
      pend_cnt  <= '0;
      filled    <= '0;
    end else begin
      if (alloc_en) begin
        pc_mem[alloc_ptr] <= alloc_pc;
        alloc_ptr         <= alloc_ptr + PW'(1);
      end
      // Clear on read before set on fill so a same-slot fill is never lost.
      if (read_en) begin
        filled[read_ptr] <= 1'b0;
        read_ptr         <= read_ptr + PW'(1);
      end
      if (fill_en) begin
        inst_mem[fill_ptr] <= fill_data;
        filled[fill_ptr]   <= 1'b1;
        fill_ptr           <= fill_ptr + PW'(1);
      end
      alloc_cnt <= alloc_cnt + CW'(alloc_en) - CW'(read_en);
      pend_cnt  <= pend_cnt + CW'(alloc_en) - CW'(fill_en);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Pipelined instruction fetch: up to DEPTH reads in flight, in-order queue of
// returned instructions tagged with PC, redirect with stale-response discard.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned           PC_WIDTH   = PC_WIDTH_DEF,
  parameter int unsigned           INST_WIDTH = INST_WIDTH_DEF,
  parameter logic [PC_WIDTH-1:0]   PC_INIT    = '0,
  parameter int unsigned           DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  fetch_unit_if.master          bus,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_WIDTH-1:0] inst,
  output logic [PC_WIDTH-1:0]   inst_pc,
  input  logic                  redirect,
  input  logic [PC_WIDTH-1:0]   redirect_pc
);

  localparam int unsigned CW = cnt_width(DEPTH);

  logic [PC_WIDTH-1:0] fetch_pc;
  logic [CW-1:0]       discard_cnt;
  logic [CW-1:0]       alloc_cnt;
  logic [CW-1:0]       pend_cnt;
  logic [CW:0]         occupancy;
  logic                issue_hs;
  logic                rsp_drop;
  logic                rsp_fill;
  logic                consume;

  assign occupancy         = {1'b0, alloc_cnt} + {1'b0, discard_cnt};
  assign bus.i_raddr_valid = !rst && (occupancy < (CW+1)'(DEPTH));
  assign bus.i_raddr       = fetch_pc;
  assign bus.i_rdata_ready = 1'b1;

  assign issue_hs = bus.i_raddr_valid && bus.i_raddr_ready;
  assign rsp_drop = bus.i_rdata_valid && (discard_cnt != '0);
  assign rsp_fill = bus.i_rdata_valid && (discard_cnt == '0);
  assign consume  = inst_valid && inst_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= PC_INIT;
      discard_cnt <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc & ~PC_WIDTH'(3);
      // Every old-stream request still owed a response becomes stale; an
      // accepted response this cycle settles one of them either way.
      discard_cnt <= discard_cnt + pend_cnt + CW'(issue_hs) - CW'(bus.i_rdata_valid);
    end else begin
      if (issue_hs)
        fetch_pc <= fetch_pc + PC_WIDTH'(FETCH_PC_INCR);
      if (rsp_drop)
        discard_cnt <= discard_cnt - CW'(1);
    end
  end

  fetch_queue #(
    .PC_WIDTH   (PC_WIDTH),
    .INST_WIDTH (INST_WIDTH),
    .DEPTH      (DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect),
    .alloc_en   (issue_hs),
    .alloc_pc   (fetch_pc),
    .fill_en    (rsp_fill),
    .fill_data  (bus.i_rdata),
    .read_en    (consume),
    .head_valid (inst_valid),
    .head_inst  (inst),
    .head_pc    (inst_pc),
    .alloc_cnt  (alloc_cnt),
    .pend_cnt   (pend_cnt)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit: a bus model with in-order variable latency
// and an architectural reference of the expected fetch/instruction streams.
module tb_fetch_unit;

  localparam int unsigned DEPTH   = 4;
  localparam logic [31:0] PC_INIT = 32'h0000_0100;

  logic        clk;
  logic        rst;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect;
  logic [31:0] redirect_pc;

  fetch_unit_if #(.PC_WIDTH(32), .INST_WIDTH(32)) bus ();

  fetch_unit #(
    .PC_WIDTH   (32),
    .INST_WIDTH (32),
    .PC_INIT    (PC_INIT),
    .DEPTH      (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int unsigned epoch;
    int unsigned due;
  } req_t;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Bus model and architectural reference state.
  req_t        bus_q[$];
  int unsigned cyc = 0;
  int unsigned epoch = 0;
  int unsigned buffered = 0;
  logic [31:0] exp_issue_pc;
  logic [31:0] exp_pc;
  int unsigned lat_lo = 0;
  int unsigned lat_hi = 0;
  int unsigned n_hs = 0;
  int unsigned n_cons = 0;
  bit          last_red = 0;
  bit          track_first = 0;
  logic [31:0] first_pc = '0;
  bit          saw_wrap = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_raddr_ready = 1'b0;
    bus.i_rdata_valid = 1'b0;
    bus.i_rdata = '0;
    inst_ready = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_raddr_valid", {31'd0, bus.i_raddr_valid}, 32'd0);
    check("rst_raddr", bus.i_raddr, PC_INIT);
    check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_rdata_ready", {31'd0, bus.i_rdata_ready}, 32'd1);
    rst = 1'b0;
    bus_q.delete();
    epoch++;
    buffered = 0;
    exp_issue_pc = PC_INIT;
    exp_pc = PC_INIT;
  endtask

  task automatic step(input bit rr, input bit ir, input bit red,
                      input logic [31:0] rpc, input bit red_on_col);
    int unsigned occ;
    bit          rv, hs, cons, do_red;
    logic [31:0] a;
    req_t        r;
    @(negedge clk);
    occ = bus_q.size() + buffered;
    check("occ_le_depth", {31'd0, occ <= DEPTH}, 32'd1);
    check("raddr_valid", {31'd0, bus.i_raddr_valid}, {31'd0, occ < DEPTH});
    if (occ < DEPTH) check("raddr", bus.i_raddr, exp_issue_pc);
    check("inst_valid", {31'd0, inst_valid}, {31'd0, buffered > 0});
    if (buffered > 0) begin
      check("inst_pc", inst_pc, exp_pc);
      check("inst", inst, mem_word(exp_pc));
    end
    if (track_first && inst_valid) begin
      first_pc = inst_pc;
      track_first = 0;
    end
    rv = (bus_q.size() > 0) && (bus_q[0].due <= cyc + 1);
    bus.i_rdata_valid = rv;
    bus.i_rdata = rv ? mem_word(bus_q[0].addr) : '0;
    bus.i_raddr_ready = rr;
    inst_ready = ir;
    do_red = red || (red_on_col && rv && bus.i_raddr_valid && rr);
    redirect = do_red;
    redirect_pc = rpc;
    hs = bus.i_raddr_valid && rr;
    a = bus.i_raddr;
    cons = (buffered > 0) && ir;
    @(posedge clk);
    cyc++;
    if (hs) begin
      bus_q.push_back('{a, epoch, cyc + 1 + $urandom_range(lat_hi, lat_lo)});
      if (a == 32'h0 && exp_issue_pc == 32'h0) saw_wrap = 1;
      exp_issue_pc += 32'd4;
      n_hs++;
    end
    if (rv) begin
      r = bus_q.pop_front();
      if (r.epoch == epoch) buffered++;
    end
    if (cons) begin
      buffered--;
      exp_pc += 32'd4;
      n_cons++;
    end
    if (do_red) begin
      epoch++;
      buffered = 0;
      exp_issue_pc = rpc & ~32'd3;
      exp_pc = rpc & ~32'd3;
    end
    last_red = do_red;
  endtask

  initial begin
    bit collided;
    do_reset();

    // Consumer stalled: exactly DEPTH requests go out, then issue stops.
    lat_lo = 0; lat_hi = 0;
    n_hs = 0;
    for (int i = 0; i < 10; i++) step(1, 0, 0, '0, 0);
    check("stall_handshakes", n_hs, DEPTH);

    // Zero-wait bus, always-ready consumer: one instruction per cycle.
    for (int i = 0; i < 6; i++) step(1, 1, 0, '0, 0);
    n_cons = 0;
    for (int i = 0; i < 16; i++) step(1, 1, 0, '0, 0);
    check("throughput", n_cons, 32'd16);

    // Three slow requests in flight, then redirect to an unaligned PC.
    do_reset();
    lat_lo = 8; lat_hi = 8;
    for (int i = 0; i < 3; i++) step(1, 1, 0, '0, 0);
    step(0, 1, 1, 32'h0000_2003, 0);
    track_first = 1;
    lat_lo = 0; lat_hi = 0;
    for (int i = 0; i < 25; i++) step(1, 1, 0, '0, 0);
    check("redirect_first_pc", first_pc, 32'h0000_2000);

    // Redirect coinciding with both a response and an address handshake.
    do_reset();
    lat_lo = 1; lat_hi = 1;
    collided = 0;
    for (int i = 0; i < 20 && !collided; i++) begin
      step(1, 0, 0, 32'h0000_3000, 1);
      collided = last_red;
    end
    check("collision_redirect", {31'd0, collided}, 32'd1);
    for (int i = 0; i < 20; i++) step(1, 1, 0, '0, 0);

    // PC wraps from the top of the address space to zero.
    lat_lo = 0; lat_hi = 0;
    saw_wrap = 0;
    step(1, 1, 1, 32'hFFFF_FFF8, 0);
    for (int i = 0; i < 12; i++) step(1, 1, 0, '0, 0);
    check("pc_wrap", {31'd0, saw_wrap}, 32'd1);

    // Random latency, back-pressure and redirects, with a reset midway.
    lat_lo = 0; lat_hi = 5;
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset();
      step($urandom_range(3, 0) != 0, $urandom_range(2, 0) != 0,
           $urandom_range(39, 0) == 0, $urandom, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
